// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT ping-pong bank scheduler.
//   bank_state_e : life cycle of one working-memory bank
//   NUM_BANKS    : number of ping-pong banks behind the memory mux
package fft_sched_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [2:0] {
    BANK_EMPTY   = 3'd0,
    BANK_LOADING = 3'd1,
    BANK_LOADED  = 3'd2,
    BANK_XFORM   = 3'd3,
    BANK_DONE    = 3'd4,
    BANK_READING = 3'd5
  } bank_state_e;

endpackage

// File: rtl/fft_bank_fsm.sv
// Life-cycle tracker for a single FFT working-memory bank.
// The top level only raises a strobe when it is legal for this bank, so
// each strobe is consumed in exactly one state.
//   clk, rst_n : clock, async active-low reset
//   ld_gnt     : bank handed to the loader      (EMPTY   -> LOADING)
//   ld_done    : loader finished the bank       (LOADING -> LOADED)
//   xf_start   : FFT core started on the bank   (LOADED  -> XFORM)
//   xf_done    : FFT core finished the bank     (XFORM   -> DONE)
//   rd_gnt     : bank handed to the reader      (DONE    -> READING)
//   rd_done    : reader finished the bank       (READING -> EMPTY)
//   state      : current bank state (bank_state_e encoding)
module fft_bank_fsm
  import fft_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_gnt,
  input  logic       ld_done,
  input  logic       xf_start,
  input  logic       xf_done,
  input  logic       rd_gnt,
  input  logic       rd_done,
  output logic [2:0] state
);

  bank_state_e state_q;
  bank_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BANK_EMPTY:   if (ld_gnt)   state_d = BANK_LOADING;
      BANK_LOADING: if (ld_done)  state_d = BANK_LOADED;
      BANK_LOADED:  if (xf_start) state_d = BANK_XFORM;
      BANK_XFORM:   if (xf_done)  state_d = BANK_DONE;
      BANK_DONE:    if (rd_gnt)   state_d = BANK_READING;
      BANK_READING: if (rd_done)  state_d = BANK_EMPTY;
      default:                    state_d = BANK_EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/fft_bank_sched.sv
// Ping-pong bank scheduler for the two FFT working memories. Each bank is
// handed in strict frame order to the loader, the FFT core and the reader;
// wmem_id steers the memory mux onto the bank owned by the FFT core.
//   clk, rst_n             : clock, async active-low reset
//   load_req / load_gnt    : loader request (level) / grant pulse
//   load_bank              : bank granted to the loader, held until next grant
//   load_done              : loader finished load_bank
//   fft_start / fft_done   : FFT core start pulse / completion pulse
//   wmem_id                : bank owned by the FFT core (mux select)
//   fft_busy               : FFT core owns a bank
//   rd_req / rd_gnt        : reader request (level) / grant pulse
//   rd_bank                : bank granted to the reader
//   rd_done                : reader finished rd_bank
//   load_stall             : load_req pending without a grant
//   err_proto              : sticky protocol error (stray done pulse)
//   frame_cnt              : frames fully read out, wrapping
//   bank_state             : {bank1, bank0} states for debug
module fft_bank_sched
  import fft_sched_pkg::*;
#(
  parameter int FFT_SIZE  = 4096,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_req,
  output logic                 load_gnt,
  output logic                 load_bank,
  input  logic                 load_done,
  output logic                 fft_start,
  output logic                 wmem_id,
  output logic                 fft_busy,
  input  logic                 fft_done,
  input  logic                 rd_req,
  output logic                 rd_gnt,
  output logic                 rd_bank,
  input  logic                 rd_done,
  output logic                 load_stall,
  output logic                 err_proto,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [5:0]           bank_state
);

  // Frame size only matters to the loader/reader; reject a nonsensical one early.
  if (FFT_SIZE < 2 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_size
    $error("fft_bank_sched: FFT_SIZE must be a power of two >= 2");
  end

  logic       ld_ptr;
  logic       fft_ptr;
  logic       rd_ptr;
  logic [2:0] st [NUM_BANKS];

  logic any_loading;
  logic any_reading;
  logic gnt_ld;
  logic go_fft;
  logic gnt_rd;
  logic fin_ld;
  logic fin_fft;
  logic fin_rd;
  logic stray_done;

  assign any_loading = (st[0] == BANK_LOADING) || (st[1] == BANK_LOADING);
  assign any_reading = (st[0] == BANK_READING) || (st[1] == BANK_READING);

  // Grants/starts: only the bank the stage pointer names may be taken,
  // which keeps the banks in frame order. One load in flight at a time.
  assign gnt_ld = load_req && (st[ld_ptr] == BANK_EMPTY) && !any_loading;
  assign go_fft = !fft_busy && (st[fft_ptr] == BANK_LOADED);
  assign gnt_rd = rd_req && (st[rd_ptr] == BANK_DONE);

  // Completions: the bank in a stage is always the one its pointer names,
  // because a pointer only moves on that stage's completion.
  assign fin_ld  = load_done && (st[ld_ptr] == BANK_LOADING);
  assign fin_fft = fft_done && fft_busy;
  assign fin_rd  = rd_done && (st[rd_ptr] == BANK_READING);

  assign stray_done = (load_done && !any_loading) ||
                      (fft_done && !fft_busy) ||
                      (rd_done && !any_reading);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    localparam bit IDX = (i != 0);
    fft_bank_fsm u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_gnt   (gnt_ld  && (ld_ptr  == IDX)),
      .ld_done  (fin_ld  && (ld_ptr  == IDX)),
      .xf_start (go_fft  && (fft_ptr == IDX)),
      .xf_done  (fin_fft && (fft_ptr == IDX)),
      .rd_gnt   (gnt_rd  && (rd_ptr  == IDX)),
      .rd_done  (fin_rd  && (rd_ptr  == IDX)),
      .state    (st[i])
    );
  end

  assign bank_state = {st[1], st[0]};

  // Registered control outputs and stage pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr     <= 1'b0;
      fft_ptr    <= 1'b0;
      rd_ptr     <= 1'b0;
      load_gnt   <= 1'b0;
      load_bank  <= 1'b0;
      fft_start  <= 1'b0;
      wmem_id    <= 1'b0;
      fft_busy   <= 1'b0;
      rd_gnt     <= 1'b0;
      rd_bank    <= 1'b0;
      load_stall <= 1'b0;
      err_proto  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      load_gnt  <= gnt_ld;
      fft_start <= go_fft;
      rd_gnt    <= gnt_rd;
      // While load_gnt is high the request it answers is still visible;
      // that cycle is not a stall.
      load_stall <= load_req && !gnt_ld && !load_gnt;

      if (gnt_ld) load_bank <= ld_ptr;
      if (fin_ld) ld_ptr    <= ~ld_ptr;

      if (go_fft) begin
        wmem_id  <= fft_ptr;
        fft_busy <= 1'b1;
      end else if (fin_fft) begin
        fft_busy <= 1'b0;
        fft_ptr  <= ~fft_ptr;
      end

      if (gnt_rd) rd_bank <= rd_ptr;
      if (fin_rd) begin
        rd_ptr    <= ~rd_ptr;
        frame_cnt <= frame_cnt + 1'b1;
      end

      if (stray_done) err_proto <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_bank_sched.sv
module tb_fft_bank_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        load_done = 1'b0;
  logic        fft_done = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_done = 1'b0;

  logic        load_gnt, load_bank, fft_start, wmem_id, fft_busy;
  logic        rd_gnt, rd_bank, load_stall, err_proto;
  logic [15:0] frame_cnt;
  logic [5:0]  bank_state;

  logic        n_load_gnt, n_load_bank, n_fft_start, n_wmem_id, n_fft_busy;
  logic        n_rd_gnt, n_rd_bank, n_load_stall, n_err_proto;
  logic [1:0]  n_frame_cnt;
  logic [5:0]  n_bank_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_bank_sched #(.FFT_SIZE(4096), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req(load_req), .load_gnt(load_gnt), .load_bank(load_bank),
    .load_done(load_done), .fft_start(fft_start), .wmem_id(wmem_id),
    .fft_busy(fft_busy), .fft_done(fft_done), .rd_req(rd_req),
    .rd_gnt(rd_gnt), .rd_bank(rd_bank), .rd_done(rd_done),
    .load_stall(load_stall), .err_proto(err_proto),
    .frame_cnt(frame_cnt), .bank_state(bank_state)
  );

  // Narrow-counter copy, driven by the same stimulus, to observe wrap.
  fft_bank_sched #(.FFT_SIZE(4096), .CNT_WIDTH(2)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .load_req(load_req), .load_gnt(n_load_gnt), .load_bank(n_load_bank),
    .load_done(load_done), .fft_start(n_fft_start), .wmem_id(n_wmem_id),
    .fft_busy(n_fft_busy), .fft_done(fft_done), .rd_req(rd_req),
    .rd_gnt(n_rd_gnt), .rd_bank(n_rd_bank), .rd_done(rd_done),
    .load_stall(n_load_stall), .err_proto(n_err_proto),
    .frame_cnt(n_frame_cnt), .bank_state(n_bank_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_req = 1'b0; load_done = 1'b0; fft_done = 1'b0;
    rd_req = 1'b0; rd_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic exp_bank, input string tag);
    int n = 0;
    load_req = 1'b1;
    step();
    while (!load_gnt && n < 10) begin step(); n++; end
    check({tag, " load_gnt"}, load_gnt, 1);
    check({tag, " load_bank"}, load_bank, exp_bank);
    load_req = 1'b0;
    step();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  task automatic wait_start(input logic exp_bank, input string tag);
    int n = 0;
    while (!fft_start && n < 10) begin step(); n++; end
    check({tag, " fft_start"}, fft_start, 1);
    check({tag, " wmem_id"}, wmem_id, exp_bank);
  endtask

  // fft_done pulse; optionally the other bank starts back-to-back.
  task automatic fft_finish(input bit next_start, input logic exp_bank, input string tag);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check({tag, " busy cleared"}, fft_busy, 0);
    check({tag, " no start at done edge"}, fft_start, 0);
    if (next_start) begin
      step();
      check({tag, " back-to-back start"}, fft_start, 1);
      check({tag, " wmem_id"}, wmem_id, exp_bank);
    end
  endtask

  task automatic do_read(input logic exp_bank, input int exp_cnt, input int exp_ncnt, input string tag);
    int n = 0;
    rd_req = 1'b1;
    step();
    while (!rd_gnt && n < 10) begin step(); n++; end
    check({tag, " rd_gnt"}, rd_gnt, 1);
    check({tag, " rd_bank"}, rd_bank, exp_bank);
    rd_req = 1'b0;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check({tag, " frame_cnt"}, frame_cnt, exp_cnt);
    check({tag, " frame_cnt narrow"}, n_frame_cnt, exp_ncnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst load_gnt", load_gnt, 0);
    check("rst fft_start", fft_start, 0);
    check("rst rd_gnt", rd_gnt, 0);
    check("rst fft_busy", fft_busy, 0);
    check("rst err_proto", err_proto, 0);
    check("rst load_stall", load_stall, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst bank_state", bank_state, 0);

    // First frame, exact latencies
    load_req = 1'b1;
    step();
    check("f0 load_gnt", load_gnt, 1);
    check("f0 load_bank", load_bank, 0);
    check("f0 bank0 LOADING", bank_state, 6'o01);
    check("f0 no stall", load_stall, 0);
    load_req = 1'b0;
    step();
    check("f0 gnt pulse", load_gnt, 0);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    check("f0 bank0 LOADED", bank_state, 6'o02);
    check("f0 start not yet", fft_start, 0);
    step();
    check("f0 fft_start", fft_start, 1);
    check("f0 wmem_id", wmem_id, 0);
    check("f0 fft_busy", fft_busy, 1);
    check("f0 bank0 XFORM", bank_state, 6'o03);
    step();
    check("f0 start pulse", fft_start, 0);
    check("f0 busy held", fft_busy, 1);

    // Steady stream: loader on the other bank while the FFT runs
    do_load(1, "f1");
    check("f1 wmem_id stable", wmem_id, 0);
    check("f1 states", bank_state, 6'o23);
    fft_finish(1, 1, "x0");
    do_read(0, 1, 1, "r0");
    do_load(0, "f2");
    fft_finish(1, 0, "x1");
    do_read(1, 2, 2, "r1");
    do_load(1, "f3");
    fft_finish(1, 1, "x2");
    do_read(0, 3, 3, "r2");
    do_load(0, "f4");
    fft_finish(1, 0, "x3");
    do_read(1, 4, 0, "r3");
    fft_finish(0, 0, "x4");
    do_read(0, 5, 1, "r4");
    check("stream err_proto", err_proto, 0);

    // Both banks DONE, stray fft_done, loader stalled
    do_reset();
    do_load(0, "s0");
    wait_start(0, "s0");
    do_load(1, "s1");
    fft_finish(1, 1, "sx0");
    fft_finish(0, 0, "sx1");
    check("both DONE", bank_state, 6'o44);
    check("err before stray", err_proto, 0);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("stray fft_done err", err_proto, 1);
    check("stray fft_done states", bank_state, 6'o44);
    check("stray fft_done busy", fft_busy, 0);
    load_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall high", load_stall, 1);
      check("stall no gnt", load_gnt, 0);
    end
    rd_req = 1'b1;
    step();
    check("stall rd_gnt", rd_gnt, 1);
    check("stall rd_bank", rd_bank, 0);
    rd_req = 1'b0;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("freed bank0", bank_state, 6'o40);
    check("no gnt at done edge", load_gnt, 0);
    step();
    check("gnt after free", load_gnt, 1);
    check("gnt after free bank", load_bank, 0);
    check("stall cleared", load_stall, 0);
    load_req = 1'b0;
    check("err sticky", err_proto, 1);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    step();
    check("mid start", fft_start, 1);
    check("mid XFORM", bank_state, 6'o43);

    // Asynchronous reset mid-XFORM
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst outputs",
          {load_gnt, load_bank, fft_start, wmem_id, fft_busy, rd_gnt, rd_bank, load_stall, err_proto}, 0);
    check("async rst frame_cnt", frame_cnt, 0);
    check("async rst bank_state", bank_state, 0);
    step();
    rst_n = 1'b1;
    load_req = 1'b1;
    step();
    check("post rst load_gnt", load_gnt, 1);
    check("post rst load_bank", load_bank, 0);
    load_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
